// File: rtl/console_tx_pkg.sv
// Shared definitions for the console transmitter: TX state encoding and
// data-bus decode constants.
package console_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] FINI_MAGIC       = 32'h0002_0000;
    localparam int          CONSOLE_ADDR_BIT = 31;
    localparam logic [31:0] LOW_ADDR_LIMIT   = 32'h1000_0000;

    function automatic logic is_console_sel(input logic [31:0] addr);
        return addr[CONSOLE_ADDR_BIT];
    endfunction

endpackage

// File: rtl/console_tx_sync_fifo.sv
// Synchronous byte FIFO with occupancy count; read data is the current head
// entry, valid whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/console_tx.sv
// Memory-mapped console: CPU writes are queued into a byte FIFO and sent as
// 8N1 UART frames; a magic write value raises a sticky finish flag instead.
module console_tx
    import console_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dbus_addr_i,
    input  logic        dbus_wvalid_i,
    input  logic [31:0] dbus_wdata_i,
    output logic        dbus_wready_o,
    output logic        txd_o,
    output logic        busy_o,
    output logic        fini_o
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int TW  = $clog2(DIV);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(DIV - 1);

    logic          sel_s;
    logic          low_addr_s;
    logic          is_fini_s;
    logic          accept_s;
    logic          push_s;
    logic          fini_set_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic [7:0]    head_s;

    tx_state_e     state_r;
    tx_state_e     state_nxt_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nxt_s;
    logic [2:0]    bit_idx_r;
    logic [2:0]    bit_idx_nxt_s;
    logic [7:0]    shifter_r;
    logic [7:0]    shifter_nxt_s;
    logic          txd_r;
    logic          txd_nxt_s;
    logic          timer_done_s;
    logic          fini_r;

    assign sel_s      = is_console_sel(dbus_addr_i);
    assign low_addr_s = (dbus_addr_i < LOW_ADDR_LIMIT);
    assign is_fini_s  = (dbus_wdata_i == FINI_MAGIC);
    assign accept_s   = sel_s && dbus_wvalid_i && !full_s && !rst_i;
    // Low-address writes would always be plain data; the select bit makes that unreachable.
    assign push_s     = accept_s && (low_addr_s || !is_fini_s);
    assign fini_set_s = accept_s && !low_addr_s && is_fini_s;

    assign dbus_wready_o = !full_s;
    assign txd_o         = txd_r;
    assign fini_o        = fini_r;
    assign busy_o        = (state_r != ST_IDLE) || (count_s != CW'(0));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push_s),
        .push_data (dbus_wdata_i[7:0]),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    assign timer_done_s = (timer_r == TIMER_LAST);

    // Frame sequencer: next state, bit timer, shifter and the next line level.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        bit_idx_nxt_s = bit_idx_r;
        shifter_nxt_s = shifter_r;
        pop_s         = 1'b0;
        txd_nxt_s     = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s         = 1'b1;
                    shifter_nxt_s = head_s;
                    state_nxt_s   = ST_START;
                    timer_nxt_s   = TW'(0);
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (timer_done_s) begin
                    state_nxt_s   = ST_DATA;
                    timer_nxt_s   = TW'(0);
                    bit_idx_nxt_s = 3'd0;
                end else begin
                    timer_nxt_s   = timer_r + TW'(1);
                end
            end
            ST_DATA: begin
                if (timer_done_s) begin
                    timer_nxt_s   = TW'(0);
                    shifter_nxt_s = {1'b0, shifter_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    timer_nxt_s   = timer_r + TW'(1);
                end
            end
            ST_STOP: begin
                if (timer_done_s) begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = TW'(0);
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = TW'(0);
            end
        endcase
        // Line level is derived from where the FSM will be, so txd_r tracks the state exactly.
        case (state_nxt_s)
            ST_START: txd_nxt_s = 1'b0;
            ST_DATA:  txd_nxt_s = shifter_nxt_s[0];
            default:  txd_nxt_s = 1'b1;
        endcase
    end

    // Sequencer registers, registered line output and sticky finish flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            timer_r   <= TW'(0);
            bit_idx_r <= 3'd0;
            shifter_r <= 8'h00;
            txd_r     <= 1'b1;
            fini_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shifter_r <= shifter_nxt_s;
            txd_r     <= txd_nxt_s;
            fini_r    <= fini_r | fini_set_s;
        end
    end

endmodule

// File: tb/tb_console_tx.sv
// Self-checking bench for console_tx: a frame-level model predicts every output
// each cycle, while a UART receiver and literal checks pin the model.
module tb_console_tx;

    localparam int DIV   = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] dbus_addr_i = 32'h0;
    logic        dbus_wvalid_i = 1'b0;
    logic [31:0] dbus_wdata_i = 32'h0;
    logic        dbus_wready_o;
    logic        txd_o;
    logic        busy_o;
    logic        fini_o;

    console_tx #(
        .CLK_FREQ   (8),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .dbus_addr_i   (dbus_addr_i),
        .dbus_wvalid_i (dbus_wvalid_i),
        .dbus_wdata_i  (dbus_wdata_i),
        .dbus_wready_o (dbus_wready_o),
        .txd_o         (txd_o),
        .busy_o        (busy_o),
        .fini_o        (fini_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: FIFO as a queue, line waveform as a queue of per-cycle levels
    // (each frame is 10*DIV bit-cycles followed by one mandatory idle cycle).
    logic [7:0] m_q[$];
    bit         m_wave[$];
    logic       m_fini = 1'b0;
    logic       m_acc, m_load;
    logic [7:0] m_b;
    logic       exp_txd, exp_busy, exp_fini, exp_wready;

    initial begin
        forever begin
            @(posedge clk);
            if (rst_i) begin
                m_q.delete();
                m_wave.delete();
                m_fini = 1'b0;
            end else begin
                m_acc  = dbus_addr_i[31] && dbus_wvalid_i && (m_q.size() < DEPTH);
                m_load = (m_wave.size() == 0) && (m_q.size() > 0);
                if (m_load) begin
                    m_b = m_q.pop_front();
                    for (int k = 0; k < DIV; k++) m_wave.push_back(1'b0);
                    for (int i = 0; i < 8; i++)
                        for (int k = 0; k < DIV; k++) m_wave.push_back(m_b[i]);
                    for (int k = 0; k < DIV; k++) m_wave.push_back(1'b1);
                    m_wave.push_back(1'b1);
                end
                if (m_acc) begin
                    if (dbus_wdata_i == 32'h0002_0000) m_fini = 1'b1;
                    else m_q.push_back(dbus_wdata_i[7:0]);
                end
            end
            exp_txd    = (m_wave.size() > 0) ? m_wave.pop_front() : 1'b1;
            exp_busy   = (m_wave.size() > 0) || (m_q.size() > 0);
            exp_fini   = m_fini;
            exp_wready = (m_q.size() < DEPTH);
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("txd", txd_o, exp_txd);
                check("busy", busy_o, exp_busy);
                check("fini", fini_o, exp_fini);
                check("wready", dbus_wready_o, exp_wready);
            end
        end
    end

    // Independent UART receiver: mid-bit sampling of txd_o.
    logic [7:0] rx_q[$];
    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge clk);
            if (chk_en && txd_o === 1'b0) begin
                repeat (3) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    rb[i] = txd_o;
                end
                repeat (DIV) @(negedge clk);
                rx_q.push_back(rb);
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); #1;
        dbus_addr_i = a; dbus_wdata_i = d; dbus_wvalid_i = 1'b1;
        @(posedge clk); #1;
        dbus_wvalid_i = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (busy_o === 1'b0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s: busy_o still high after %0d cycles, required low", name, max_cycles);
        end
    endtask

    task automatic wait_txd_low(input int max_cycles, input string name);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (txd_o === 1'b0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s: no start bit within %0d cycles", name, max_cycles);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       wr[6];
        logic [7:0] abcde[5];
        abcde = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};

        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        chk_en = 1'b1;
        check("reset_txd", txd_o, 1'b1);
        check("reset_busy", busy_o, 1'b0);
        check("reset_fini", fini_o, 1'b0);
        check("reset_wready", dbus_wready_o, 1'b1);
        repeat (4) @(negedge clk);

        // Single 0x55 frame.
        bus_write(32'h8000_0000, 32'h0000_0055);
        wait_idle(200, "frame55_idle");
        check("frame55_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("frame55_byte", rx_q[0], 8'h55);
        rx_q.delete();

        // Finish magic: flag only, no frame.
        bus_write(32'h8000_0000, 32'h0002_0000);
        check("fini_set", fini_o, 1'b1);
        check("fini_busy", busy_o, 1'b0);
        check("fini_txd", txd_o, 1'b1);

        // Unselected address ignored.
        bus_write(32'h0000_1000, 32'h0000_0077);
        repeat (100) @(negedge clk);
        check("unsel_frames", rx_q.size(), 0);
        check("unsel_busy", busy_o, 1'b0);

        // Six back-to-back writes into a 4-deep FIFO.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            dbus_addr_i = 32'h8000_0000;
            dbus_wdata_i = 32'h0000_0041 + 32'(i);
            dbus_wvalid_i = 1'b1;
            wr[i] = dbus_wready_o;
            @(posedge clk); #1;
        end
        dbus_wvalid_i = 1'b0;
        check("b2b_wready5", wr[4], 1'b1);
        check("b2b_wready6", wr[5], 1'b0);
        wait_idle(600, "b2b_idle");
        check("b2b_count", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) check("b2b_byte", rx_q[i], abcde[i]);
        rx_q.delete();

        // Reset 30 cycles into a frame, with a concurrent write that must be dropped.
        bus_write(32'h8000_0000, 32'h0000_00C3);
        wait_txd_low(20, "abort_start");
        repeat (30) @(negedge clk);
        #1;
        rst_i = 1'b1;
        dbus_addr_i = 32'h8000_0000; dbus_wdata_i = 32'h0000_0099; dbus_wvalid_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0; dbus_wvalid_i = 1'b0;
        check("abort_txd", txd_o, 1'b1);
        check("abort_busy", busy_o, 1'b0);
        check("abort_fini", fini_o, 1'b0);
        check("abort_wready", dbus_wready_o, 1'b1);
        repeat (100) @(negedge clk);
        rx_q.delete();
        bus_write(32'h8000_0000, 32'h0000_005A);
        wait_idle(200, "frame5a_idle");
        check("frame5a_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("frame5a_byte", rx_q[0], 8'h5A);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/console_tx.md
CONSOLE_TX -- requirements
Module: console_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 1_000_000, serial bit rate; DIV = CLK_FREQ/BAUD, DIV >= 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, byte FIFO entries.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port dbus_addr_i  input  32  CPU data-bus address.
REQ-007 SHALL have port dbus_wvalid_i  input  1  CPU write strobe.
REQ-008 SHALL have port dbus_wdata_i  input  32  CPU write data.
REQ-009 SHALL have port dbus_wready_o  output  1  write accept; low while FIFO full.
REQ-010 SHALL have port txd_o  output  1  UART serial out, idle high.
REQ-011 SHALL have port busy_o  output  1  high while FIFO non-empty or frame in flight.
REQ-012 SHALL have port fini_o  output  1  sticky simulation/program-finish flag.

Function
REQ-013 Device select: dbus_addr_i[31]==1; writes with addr[31]==0 SHALL be ignored.
REQ-014 Accepted write = select && dbus_wvalid_i && dbus_wready_o.
REQ-015 Accepted write with wdata==32'h00020000 SHALL set fini_o next cycle and SHALL NOT enqueue.
REQ-016 Accepted write with dbus_addr_i < 32'h10000000 (after select check, i.e. never, kept for decode symmetry) SHALL be treated as ordinary data; only wdata[7:0] enqueued.
REQ-017 Other accepted writes SHALL push wdata[7:0] into FIFO; upper bits discarded.
REQ-018 Write while FIFO full SHALL be refused (wready_o=0), FIFO and count unchanged.
REQ-019 dbus_wready_o SHALL be combinational: !full.
REQ-020 FIFO count width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
REQ-021 Simultaneous push and pop SHALL be allowed when non-empty; count unchanged.
REQ-022 TX FSM states IDLE, START, DATA, STOP.
REQ-023 IDLE: txd_o=1; if FIFO non-empty, pop head into shifter, go START, bit timer=0.
REQ-024 START: txd_o=0 for DIV cycles, then DATA with bit index 0.
REQ-025 DATA: txd_o=shifter[0], LSB first, DIV cycles per bit; after bit 7 go STOP.
REQ-026 STOP: txd_o=1 for DIV cycles, then IDLE; frame = 10*DIV cycles.
REQ-027 Back-to-back frames SHALL have exactly one IDLE cycle between STOP end and next START.
REQ-028 busy_o = (state!=IDLE) || !empty.
REQ-029 txd_o SHALL be registered (glitch-free).

Reset
REQ-030 rst_i SHALL force: state IDLE, txd_o=1, FIFO empty, count 0, busy_o=0, fini_o=0, dbus_wready_o=1.
REQ-031 Reset asserted mid-frame SHALL abort frame; txd_o=1 on the cycle after reset sampled.
REQ-032 Writes in the same cycle as rst_i SHALL be discarded.

Structure
REQ-033 Shared package SHALL hold TX state enum, FINI_MAGIC=32'h00020000, CONSOLE_ADDR_BIT=31.
REQ-034 FIFO SHALL be sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count).
REQ-035 Total RTL 120-400 lines; no vendor primitives.

Verification (CLK_FREQ=8, BAUD=1, DIV=8, FIFO_DEPTH=4)
REQ-036 Write 0x80000000/0x00000055 -> txd_o: 0 for 8 cycles, then 1,0,1,0,1,0,1,0 each 8 cycles, 1 for 8 cycles; busy_o low after.
REQ-037 Write wdata 0x00020000 -> fini_o=1 next cycle, txd_o stays 1, busy_o stays 0.
REQ-038 Write to 0x00001000 -> no frame, FIFO count 0.
REQ-039 6 back-to-back writes 0x41..0x46 -> first popped, 4 queued, 6th refused (wready_o=0); frames "ABCDE" emitted in order, one IDLE gap each.
REQ-040 Assert rst_i 30 cycles into a frame -> txd_o=1, busy_o=0, fini_o=0 next cycle; fresh write of 0x5A transmits correctly.
